// File: rtl/spi_master_ctrl_if.sv
// Host-side command/response bus of spi_master_ctrl: command, transfer
// parameters, stall back-pressure and the receive buffer.
interface spi_master_ctrl_if #(
    parameter int W_DATA = 32,
    parameter int N_CS   = 4,
    parameter int W_DIV  = 8
);
    localparam int W_SEL = (N_CS > 1) ? $clog2(N_CS) : 1;

    logic [1:0]        spi_ctrl;
    logic [W_DATA-1:0] wdata;
    logic [W_SEL-1:0]  cs_sel;
    logic [1:0]        mode;
    logic [W_DIV-1:0]  div;
    logic              stall;
    logic [W_DATA-1:0] rdata;
    logic              rx_valid;
    logic              cs_err;

    modport master (
        output spi_ctrl, wdata, cs_sel, mode, div,
        input  stall, rdata, rx_valid, cs_err
    );

    modport slave (
        input  spi_ctrl, wdata, cs_sel, mode, div,
        output stall, rdata, rx_valid, cs_err
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-word SPI master: accepts a transfer command in IDLE, runs
// SETUP/SHIFT/HOLD with a programmable sclk half-period, buffers the received word.
module spi_master_ctrl #(
    parameter int W_DATA = 32,
    parameter int N_CS   = 4,
    parameter int W_DIV  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_ctrl_if.slave bus,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic [N_CS-1:0]  cs_n
);
    localparam int W_SEL = (N_CS > 1) ? $clog2(N_CS) : 1;
    localparam int W_HP  = $clog2(2 * W_DATA);
    localparam logic [W_HP-1:0]   HP_LAST  = W_HP'(2 * W_DATA - 1);
    localparam logic [W_SEL:0]    N_CS_LIM = (W_SEL + 1)'(N_CS);
    localparam logic [N_CS-1:0]   CS_ONE   = N_CS'(1);
    localparam logic [1:0]        SPI_NOP  = 2'd0;
    localparam logic [1:0]        CMD_MOSI = 2'd1;
    localparam logic [1:0]        CMD_MISO = 2'd2;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state;
    logic [W_DIV-1:0]  div_q;
    logic [W_DIV-1:0]  div_cnt;
    logic [W_HP-1:0]   hp_cnt;
    logic              cpol_q;
    logic              cpha_q;
    logic [W_DATA-1:0] tx_sr;
    logic [W_DATA-1:0] rx_sr;
    logic [W_DATA-1:0] rdata_q;
    logic              rx_valid_q;
    logic              cs_err_q;

    logic half_done;
    logic sel_legal;

    // Compare before incrementing so neither counter ever wraps, even at div = all-ones.
    assign half_done = (div_cnt == div_q);
    assign sel_legal = ({1'b0, bus.cs_sel} < N_CS_LIM);

    assign bus.stall    = (bus.spi_ctrl != SPI_NOP) && (state != IDLE);
    assign bus.rdata    = rdata_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.cs_err   = cs_err_q;

    // NOTE: every register here uses <= so all of them see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: reset is synchronous; the shift registers are cleared too so no stale bits survive an abort.
            state      <= IDLE;
            div_q      <= '0;
            div_cnt    <= '0;
            hp_cnt     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rdata_q    <= '0;
            rx_valid_q <= 1'b0;
            cs_err_q   <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= '1;
        end else begin
            cs_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cpol_q;
                    mosi <= 1'b0;
                    cs_n <= '1;
                    if (bus.spi_ctrl == CMD_MISO) begin
                        rx_valid_q <= 1'b0;
                    end else if (bus.spi_ctrl == CMD_MOSI) begin
                        if (sel_legal) begin
                            tx_sr   <= bus.wdata;
                            cpol_q  <= bus.mode[1];
                            cpha_q  <= bus.mode[0];
                            div_q   <= bus.div;
                            div_cnt <= '0;
                            hp_cnt  <= '0;
                            sclk    <= bus.mode[1];
                            mosi    <= bus.wdata[W_DATA-1];
                            cs_n    <= ~(CS_ONE << bus.cs_sel);
                            state   <= SETUP;
                        end else begin
                            cs_err_q <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        sclk    <= ~cpol_q;
                        state   <= SHIFT;
                        // First leading edge: cpha=0 samples here; cpha=1 keeps the MSB already on mosi.
                        if (!cpha_q)
                            rx_sr <= {rx_sr[W_DATA-2:0], miso};
                    end else begin
                        div_cnt <= div_cnt + W_DIV'(1);
                    end
                end

                SHIFT: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (hp_cnt == HP_LAST) begin
                            state <= HOLD;
                        end else begin
                            hp_cnt <= hp_cnt + W_HP'(1);
                            sclk   <= ~sclk;
                            // Even half-periods end on a trailing edge, odd ones on a leading edge.
                            if (hp_cnt[0] != cpha_q) begin
                                rx_sr <= {rx_sr[W_DATA-2:0], miso};
                            end else begin
                                tx_sr <= {tx_sr[W_DATA-2:0], 1'b0};
                                mosi  <= tx_sr[W_DATA-2];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + W_DIV'(1);
                    end
                end

                HOLD: begin
                    sclk <= cpol_q;
                    if (half_done) begin
                        div_cnt    <= '0;
                        cs_n       <= '1;
                        mosi       <= 1'b0;
                        rdata_q    <= rx_sr;
                        rx_valid_q <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + W_DIV'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized bench for spi_master_ctrl: a behavioural SPI slave plus a
// word-level model of the receive buffer and transfer timing.
module tb_spi_master_ctrl;
    localparam int W_DATA = 8;
    localparam int N_CS   = 5;
    localparam int W_DIV  = 4;
    localparam int W_SEL  = $clog2(N_CS);
    localparam logic [1:0] C_NOP  = 2'd0;
    localparam logic [1:0] C_MOSI = 2'd1;
    localparam logic [1:0] C_MISO = 2'd2;
    localparam int LIMIT = 5000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sclk, mosi, miso;
    logic [N_CS-1:0] cs_n;

    spi_master_ctrl_if #(.W_DATA(W_DATA), .N_CS(N_CS), .W_DIV(W_DIV)) bus ();

    spi_master_ctrl #(.W_DATA(W_DATA), .N_CS(N_CS), .W_DIV(W_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso),
        .cs_n  (cs_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state of the receive buffer.
    logic [W_DATA-1:0] exp_rdata = '0;
    logic              exp_rx_valid = 1'b0;

    // Behavioural SPI slave.
    logic              loopback = 1'b0;
    logic              slave_bit = 1'b0;
    logic [1:0]        slave_mode = 2'b00;
    logic [W_DATA-1:0] slave_word = '0;
    logic [W_DATA-1:0] slave_sr = '0;
    logic [W_DATA-1:0] slave_rx = '0;
    logic              s_prev_active = 1'b0;
    logic              s_prev_sclk = 1'b0;
    logic              s_active, s_cpol, s_cpha;

    assign miso = loopback ? mosi : slave_bit;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin : slave_model
        forever begin
            @(negedge clk);
            s_active = (cs_n != '1);
            if (s_active && !s_prev_active) begin
                s_cpol   = slave_mode[1];
                s_cpha   = slave_mode[0];
                slave_sr = slave_word;
                slave_rx = '0;
                if (!s_cpha) begin
                    slave_bit = slave_sr[W_DATA-1];
                    slave_sr  = slave_sr << 1;
                end
            end else if (s_active && sclk != s_prev_sclk) begin
                if ((sclk != s_cpol) == !s_cpha) begin
                    slave_rx = {slave_rx[W_DATA-2:0], mosi};
                end else begin
                    slave_bit = slave_sr[W_DATA-1];
                    slave_sr  = slave_sr << 1;
                end
            end
            s_prev_active = s_active;
            s_prev_sclk   = sclk;
        end
    end

    // Starts at a negedge with the block idle; returns at the first idle negedge after the transfer.
    task automatic xfer(input logic [W_DATA-1:0] word, input int sel, input logic [1:0] md,
                        input int dv, input logic [W_DATA-1:0] sword, input logic lb,
                        input logic [1:0] busy_cmd);
        int h, busy, low_cnt, edges, last_edge, cyc;
        logic cs_ok, stall_ok, tim_ok, rxv_ok, prev_s, done;
        logic [N_CS-1:0] exp_cs;
        h    = dv + 1;
        busy = h * (2 * W_DATA + 2);
        exp_cs = '1;
        exp_cs[sel] = 1'b0;
        loopback   = lb;
        slave_word = sword;
        slave_mode = md;
        bus.spi_ctrl = C_MOSI;
        bus.wdata    = word;
        bus.cs_sel   = W_SEL'(sel);
        bus.mode     = md;
        bus.div      = W_DIV'(dv);
        #1 check("accept_stall", bus.stall, 0);
        @(posedge clk);
        #1 bus.spi_ctrl = busy_cmd;
        low_cnt = 0; edges = 0; last_edge = 0; done = 1'b0;
        cs_ok = 1'b1; stall_ok = 1'b1; tim_ok = 1'b1; rxv_ok = 1'b1;
        prev_s = md[1];
        for (cyc = 1; cyc <= LIMIT; cyc++) begin
            @(negedge clk);
            if (cs_n == '1) begin
                done = 1'b1;
                break;
            end
            low_cnt++;
            if (cs_n !== exp_cs) cs_ok = 1'b0;
            if (bus.stall !== (busy_cmd != C_NOP)) stall_ok = 1'b0;
            if (bus.rx_valid !== exp_rx_valid) rxv_ok = 1'b0;
            if (sclk !== prev_s) begin
                edges++;
                if (edges == 1) begin
                    if (cyc != h + 1) tim_ok = 1'b0;
                end else if (cyc - last_edge != h) begin
                    tim_ok = 1'b0;
                end
                last_edge = cyc;
            end
            prev_s = sclk;
            // Inputs wander during the transfer; only the accept-cycle values may matter.
            bus.wdata  = W_DATA'($urandom);
            bus.cs_sel = W_SEL'($urandom);
            bus.mode   = 2'($urandom);
            bus.div    = W_DIV'($urandom);
        end
        check("xfer_done", done, 1);
        check("idle_stall", bus.stall, 0);
        bus.spi_ctrl = C_NOP;
        check("busy_cycles", low_cnt, busy);
        check("cs_n_busy", cs_ok, 1);
        check("stall_busy", stall_ok, 1);
        check("rx_valid_busy", rxv_ok, 1);
        check("sclk_edges", edges, 2 * W_DATA);
        check("sclk_timing", tim_ok, 1);
        check("idle_sclk", sclk, md[1]);
        check("idle_mosi", mosi, 0);
        check("mosi_word", slave_rx, word);
        exp_rdata    = lb ? word : sword;
        exp_rx_valid = 1'b1;
        check("rdata", bus.rdata, exp_rdata);
        check("rx_valid", bus.rx_valid, exp_rx_valid);
    endtask

    task automatic miso_read();
        bus.spi_ctrl = C_MISO;
        #1;
        check("read_rdata", bus.rdata, exp_rdata);
        check("read_valid", bus.rx_valid, exp_rx_valid);
        @(posedge clk);
        #1 bus.spi_ctrl = C_NOP;
        @(negedge clk);
        exp_rx_valid = 1'b0;
        check("read_clr_valid", bus.rx_valid, exp_rx_valid);
        check("read_keep_rdata", bus.rdata, exp_rdata);
    endtask

    task automatic bad_cs(input int sel);
        bus.spi_ctrl = C_MOSI;
        bus.cs_sel   = W_SEL'(sel);
        bus.wdata    = W_DATA'($urandom);
        #1 check("bad_cs_stall", bus.stall, 0);
        @(posedge clk);
        #1 bus.spi_ctrl = C_NOP;
        @(negedge clk);
        check("cs_err_pulse", bus.cs_err, 1);
        check("bad_cs_cs_n", cs_n, {N_CS{1'b1}});
        check("bad_cs_valid", bus.rx_valid, exp_rx_valid);
        @(negedge clk);
        check("cs_err_end", bus.cs_err, 0);
        check("bad_cs_idle", cs_n, {N_CS{1'b1}});
    endtask

    // Aborts a transfer around bit 4 with a new command held through reset.
    task automatic reset_mid(input int dv);
        loopback     = 1'b1;
        slave_mode   = 2'b00;
        bus.spi_ctrl = C_MOSI;
        bus.wdata    = W_DATA'($urandom);
        bus.cs_sel   = 3;
        bus.mode     = 2'b10;
        bus.div      = W_DIV'(dv);
        @(posedge clk);
        #1 bus.spi_ctrl = C_NOP;
        repeat ((dv + 1) * 9) @(negedge clk);
        check("pre_reset_busy", (cs_n != '1), 1);
        rst_n = 1'b0;
        bus.spi_ctrl = C_MOSI;
        @(negedge clk);
        check("abort_cs_n", cs_n, {N_CS{1'b1}});
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_rdata", bus.rdata, 0);
        check("abort_valid", bus.rx_valid, 0);
        check("abort_stall", bus.stall, 0);
        exp_rdata    = '0;
        exp_rx_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int r, dv;
        bus.spi_ctrl = C_MOSI;
        bus.wdata    = 8'h5A;
        bus.cs_sel   = '0;
        bus.mode     = 2'b11;
        bus.div      = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, {N_CS{1'b1}});
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_cs_err", bus.cs_err, 0);
        check("rst_stall", bus.stall, 0);
        bus.spi_ctrl = C_NOP;
        rst_n = 1'b1;
        @(negedge clk);

        miso_read();
        xfer(8'hA5, 1, 2'b00, 0, 8'h00, 1'b1, C_NOP);
        xfer(8'h96, 1, 2'b11, 3, 8'h3C, 1'b0, C_NOP);
        xfer(8'hC3, 2, 2'b01, 1, 8'h81, 1'b0, C_MOSI);
        xfer(8'h7E, 0, 2'b10, 0, 8'hE7, 1'b0, C_NOP);
        bad_cs(5);
        reset_mid(2);
        xfer(8'h11, 4, 2'b00, 0, 8'h22, 1'b0, C_NOP);
        xfer(8'h4D, 3, 2'b01, 0, 8'hB2, 1'b0, C_MISO);
        miso_read();
        miso_read();
        xfer(8'hF0, 0, 2'b10, (1 << W_DIV) - 1, 8'h0F, 1'b0, C_NOP);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                bad_cs($urandom_range(N_CS, (1 << W_SEL) - 1));
            end else if (r == 1) begin
                miso_read();
            end else begin
                dv = ($urandom_range(0, 9) == 0) ? (1 << W_DIV) - 1 : $urandom_range(0, 3);
                xfer(W_DATA'($urandom), $urandom_range(0, N_CS - 1), 2'($urandom), dv,
                     W_DATA'($urandom), 1'($urandom), 2'($urandom_range(0, 2)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
